pipelined_adder: RTL and testbench
==================================

// Module: pipelined_adder
// PURPOSE
//  Parametrised, pipelined add/subtract unit; successor to our fixed 4-bit ripple-carry adder.
//  Splits a WIDTH-bit add into NSTAGE = WIDTH/CHUNK chunk ripple adders, one chunk per clock.
//  Carries pass between stages in registers, and operands are skewed through the pipeline.
//  Datapath arithmetic primitive with a valid/ready handshake, for use inside ALU and accumulator pipelines.
// PARAMETERS
//  WIDTH  32  operand width in bits; must be a multiple of CHUNK
//  CHUNK  8   bits added per pipeline stage; NSTAGE = WIDTH/CHUNK (>=1)
// PORTS
//  clk        in   1         rising-edge clock
//  rst        in   1         synchronous, active-high reset
//  in_valid   in   1         operand beat valid
//  in_ready   out  1         unit can accept the beat this cycle
//  p          in   WIDTH     operand A
//  q          in   WIDTH     operand B
//  c0         in   1         carry-in (add mode only)
//  sub        in   1         1: r = p - q; 0: r = p + q + c0
//  out_valid  out  1         result valid
//  out_ready  in   1         consumer accepts the result
//  r          out  WIDTH+1   result; r[WIDTH] = carry-out (in sub mode: 1 = no borrow)
//  ovf        out  1         signed two's-complement overflow of r[WIDTH-1:0]
// BEHAVIOUR
//  - Reset (rst=1 at posedge): all stage valid bits 0, all stage data 0; out_valid=0, r=0, ovf=0.
//    in_ready=1 in the first cycle after reset is released.
//  - Transfers: an input transfer is in_valid&in_ready; an output transfer is out_valid&out_ready.
//  - Sub mode: the unit computes p + ~q + 1. It inverts q at stage 0 and forces carry-in to 1; c0 is ignored.
//  - Stage k (0..NSTAGE-1): sum chunk k = a[k*CHUNK+:CHUNK] + b[..] + carry_k, where carry_0 is the effective carry-in.
//    The stage registers that sum chunk, carry_k+1, all lower result chunks, and the untouched upper operand chunks.
//  - Latency: NSTAGE cycles. A beat accepted at edge t gives out_valid=1 after edge t+NSTAGE-1
//    (NSTAGE=1: registered, 1 cycle).
//  - Throughput: 1 beat/cycle while out_ready=1. Results leave in acceptance order; none is dropped or duplicated.
//  - Stall: the whole pipeline advances only when adv = !out_valid | out_ready.
//    in_ready = adv (combinational from out_ready and out_valid only; never from in_valid).
//    While adv=0, every stage register, r and ovf hold.
//  - Bubbles: a stage whose valid bit is 0 still advances when adv=1. Bubbles collapse only at the output boundary.
//  - ovf = (a[W-1]==b'[W-1]) & (r[W-1]!=a[W-1]), where b' is q or ~q. The operand MSBs travel with the beat.
//  - r and ovf are registered outputs. They are stable while out_valid=1 and out_ready=0.
//  - Reset mid-operation: every in-flight beat is discarded, with no partial result emitted.
//  - Wrap-around: all-ones + 1 gives r[WIDTH-1:0]=0 and r[WIDTH]=1, with no saturation.
//  - The unit checks at elaboration time that WIDTH % CHUNK == 0 and CHUNK >= 1. A violation gives a $error.
// STRUCTURE
//  - Shared package: ADD_OP_ADD=1'b0 and ADD_OP_SUB=1'b1 constants, plus a stage payload struct
//    {valid, carry, a_hi, b_hi, r_lo, msb_a, msb_b}.
//  - One sub-module: chunk_adder (CHUNK-bit combinational ripple adder built from full_adder).
//    It is instantiated once per stage inside a generate loop.
//  - The top level holds the stage registers, sub-mode inversion, the adv/stall logic and the ovf computation.
// TESTING (defaults WIDTH=32, CHUNK=8, unless stated otherwise)
//  1. p=FFFFFFFF, q=00000001, c0=0, sub=0 -> 4 cycles later r=1_00000000, ovf=0.
//  2. Subtraction: p=5, q=7, sub=1, c0=1 (ignored) -> r=0_FFFFFFFE, ovf=0. Then p=7, q=5 -> r=1_00000002.
//  3. Overflow: p=7FFFFFFF, q=1, add -> r=0_80000000, ovf=1. Then p=80000000, q=1, sub -> r=1_7FFFFFFF, ovf=1.
//  4. Streaming plus backpressure: 10 back-to-back beats (p=i, q=i<<8) with out_ready=0 for cycles 3-8.
//     Expect: in_ready drops once the output is full, all 10 results appear in order, r/ovf are stable during the stall,
//     and no loss or duplication occurs.
//  5. Reset mid-stream: rst=1 for 1 cycle with 3 beats in flight -> out_valid=0 next cycle, and no stale result ever appears.
//  6. Parameter sweep (WIDTH,CHUNK) = (8,8), (8,1), (64,16): random 1000 beats vs a reference model.
//     Latency must equal NSTAGE each time.

Source files
------------

// File: rtl/pipelined_adder_pkg.sv
// Shared constants and per-stage control bundle for the pipelined adder.
// Operand-width-dependent payload fields are declared in the top module.
package pipelined_adder_pkg;

  localparam logic ADD_OP_ADD = 1'b0;
  localparam logic ADD_OP_SUB = 1'b1;

  // Width-independent part of a stage payload.
  typedef struct packed {
    logic valid;
    logic carry;
    logic msb_a;
    logic msb_b;
  } add_ctl_t;

  function automatic int add_nstage(
    input int width,
    input int chunk
  );
    if (chunk < 1 || width < chunk) begin
      return 1;
    end
    return width / chunk;
  endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for the pipelined adder.
// master drives operands and out_ready; slave is the adder.
interface pipelined_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] q;
  logic             c0;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   r;
  logic             ovf;

  modport master (
    output in_valid, p, q, c0, sub, out_ready,
    input  in_ready, out_valid, r, ovf
  );

  modport slave (
    input  in_valid, p, q, c0, sub, out_ready,
    output in_ready, out_valid, r, ovf
  );
endinterface

// File: rtl/pipelined_adder_chunk_adder.sv
// CHUNK-bit combinational ripple adder built from full adders.
// Ports: a, b operands; ci carry-in; s sum; co carry-out.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module chunk_adder #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);
  logic [W:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < W; i++) begin : g_bit
    full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  assign co = c[W];
endmodule

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract: one CHUNK-bit ripple chunk per stage.
// Ports: clk, rst (sync, active-high), bus (slave handshake).
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic               clk,
  input  logic               rst,
  pipelined_adder_if.slave   bus
);

  localparam int NSTAGE = add_nstage(WIDTH, CHUNK);
  localparam int CSAFE  = (CHUNK < 1) ? 1 : CHUNK;

  if (CHUNK < 1 || (WIDTH % CSAFE) != 0) begin : g_bad_cfg
    $error("pipelined_adder: WIDTH must be a multiple of CHUNK >= 1");
  end

  // Full operands ride along; stage k only reads chunk k of a/b.
  typedef struct packed {
    add_ctl_t         ctl;
    logic [WIDTH-1:0] a_hi;
    logic [WIDTH-1:0] b_hi;
    logic [WIDTH-1:0] r_lo;
  } stage_t;

  stage_t in_s;
  stage_t nxt  [NSTAGE];
  stage_t st_q [NSTAGE];
  stage_t last;
  logic   adv;
  logic   is_sub;

  assign is_sub = (bus.sub == ADD_OP_SUB);

  // Sub mode becomes p + ~q + 1 right at the entry.
  always_comb begin
    in_s           = '0;
    in_s.ctl.valid = bus.in_valid;
    in_s.ctl.carry = is_sub ? 1'b1 : bus.c0;
    in_s.a_hi      = bus.p;
    in_s.b_hi      = is_sub ? ~bus.q : bus.q;
    in_s.ctl.msb_a = bus.p[WIDTH-1];
    in_s.ctl.msb_b = in_s.b_hi[WIDTH-1];
  end

  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    stage_t           cur;
    stage_t           upd;
    logic [CHUNK-1:0] sum;
    logic             co;

    if (k == 0) begin : g_first
      assign cur = in_s;
    end else begin : g_next
      assign cur = st_q[k-1];
    end

    chunk_adder #(.W(CHUNK)) u_add (
      .a  (cur.a_hi[k*CHUNK +: CHUNK]),
      .b  (cur.b_hi[k*CHUNK +: CHUNK]),
      .ci (cur.ctl.carry),
      .s  (sum),
      .co (co)
    );

    always_comb begin
      upd                         = cur;
      upd.r_lo[k*CHUNK +: CHUNK]  = sum;
      upd.ctl.carry               = co;
    end

    assign nxt[k] = upd;
  end

  // Whole pipe moves in lockstep; bubbles only vanish at the output.
  assign adv          = !bus.out_valid | bus.out_ready;
  assign bus.in_ready = adv;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NSTAGE; i++) begin
        st_q[i] <= '0;
      end
    end else if (adv) begin
      for (int i = 0; i < NSTAGE; i++) begin
        st_q[i] <= nxt[i];
      end
    end
  end

  assign last          = st_q[NSTAGE-1];
  assign bus.out_valid = last.ctl.valid;
  assign bus.r         = {last.ctl.carry, last.r_lo};
  assign bus.ovf       = (last.ctl.msb_a == last.ctl.msb_b)
                       & (last.r_lo[WIDTH-1] != last.ctl.msb_a);

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed and randomised checks for pipelined_adder.
// Main instance is 32/8; three more cover the parameter sweep.
module tb_pipelined_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  pipelined_adder_if #(.WIDTH(32)) bus ();
  pipelined_adder_if #(.WIDTH(8))  bus_a ();
  pipelined_adder_if #(.WIDTH(8))  bus_b ();
  pipelined_adder_if #(.WIDTH(64)) bus_c ();

  pipelined_adder #(.WIDTH(32), .CHUNK(8)) dut (
    .clk (clk), .rst (rst), .bus (bus)
  );
  pipelined_adder #(.WIDTH(8), .CHUNK(8)) dut_a (
    .clk (clk), .rst (rst), .bus (bus_a)
  );
  pipelined_adder #(.WIDTH(8), .CHUNK(1)) dut_b (
    .clk (clk), .rst (rst), .bus (bus_b)
  );
  pipelined_adder #(.WIDTH(64), .CHUNK(16)) dut_c (
    .clk (clk), .rst (rst), .bus (bus_c)
  );

  logic        sw_iv  [3];
  logic        sw_or  [3];
  logic [63:0] sw_p   [3];
  logic [63:0] sw_q   [3];
  logic        sw_c0  [3];
  logic        sw_sub [3];
  logic        sw_ir  [3];
  logic        sw_ov  [3];
  logic [64:0] sw_r   [3];
  logic        sw_o   [3];

  assign bus_a.in_valid  = sw_iv[0];
  assign bus_a.out_ready = sw_or[0];
  assign bus_a.p         = sw_p[0][7:0];
  assign bus_a.q         = sw_q[0][7:0];
  assign bus_a.c0        = sw_c0[0];
  assign bus_a.sub       = sw_sub[0];
  assign sw_ir[0]        = bus_a.in_ready;
  assign sw_ov[0]        = bus_a.out_valid;
  assign sw_r[0]         = {56'd0, bus_a.r};
  assign sw_o[0]         = bus_a.ovf;

  assign bus_b.in_valid  = sw_iv[1];
  assign bus_b.out_ready = sw_or[1];
  assign bus_b.p         = sw_p[1][7:0];
  assign bus_b.q         = sw_q[1][7:0];
  assign bus_b.c0        = sw_c0[1];
  assign bus_b.sub       = sw_sub[1];
  assign sw_ir[1]        = bus_b.in_ready;
  assign sw_ov[1]        = bus_b.out_valid;
  assign sw_r[1]         = {56'd0, bus_b.r};
  assign sw_o[1]         = bus_b.ovf;

  assign bus_c.in_valid  = sw_iv[2];
  assign bus_c.out_ready = sw_or[2];
  assign bus_c.p         = sw_p[2];
  assign bus_c.q         = sw_q[2];
  assign bus_c.c0        = sw_c0[2];
  assign bus_c.sub       = sw_sub[2];
  assign sw_ir[2]        = bus_c.in_ready;
  assign sw_ov[2]        = bus_c.out_valid;
  assign sw_r[2]         = bus_c.r;
  assign sw_o[2]         = bus_c.ovf;

  // Reference: plain full-width add, masked to w bits.
  function automatic logic [65:0] ref_add(
    input int          w,
    input logic [63:0] p,
    input logic [63:0] q,
    input logic        c0,
    input logic        sub
  );
    logic [63:0] m;
    logic [63:0] a;
    logic [63:0] b;
    logic [64:0] s;
    logic [64:0] r;
    logic        ci;
    logic        o;
    m  = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    a  = p & m;
    b  = (sub ? ~q : q) & m;
    ci = sub ? 1'b1 : c0;
    s  = {1'b0, a} + {1'b0, b} + {64'd0, ci};
    r  = (s & {1'b0, m}) | ({64'd0, s[w]} << w);
    o  = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
    return {o, r};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if (bus.out_valid !== 1'b0)
      $display("FAIL rst_out_valid: got %b want 0", bus.out_valid);
    if (bus.out_valid !== 1'b0) fails++;
    tests++;
    if (bus.r !== 33'd0) begin
      $display("FAIL rst_r: got %h want 0", bus.r);
      fails++;
    end
    tests++;
    if (bus.ovf !== 1'b0) begin
      $display("FAIL rst_ovf: got %b want 0", bus.ovf);
      fails++;
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.in_ready !== 1'b1) begin
      $display("FAIL rst_in_ready: got %b want 1", bus.in_ready);
      fails++;
    end
  endtask

  task automatic run_beat(
    input logic [31:0] p,
    input logic [31:0] q,
    input logic        c0,
    input logic        sub,
    input logic [32:0] er,
    input logic        eo,
    input string       nm
  );
    int   k;
    logic seen;
    @(posedge clk);
    #1;
    bus.p         = p;
    bus.q         = q;
    bus.c0        = c0;
    bus.sub       = sub;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    tests++;
    if (bus.in_ready !== 1'b1) begin
      $display("FAIL %s_in_ready: got %b want 1", nm, bus.in_ready);
      fails++;
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    k    = 0;
    seen = 1'b0;
    while (!seen && k < 20) begin
      @(negedge clk);
      k++;
      if (bus.out_valid === 1'b1) seen = 1'b1;
    end
    tests++;
    if (!seen) begin
      $display("FAIL %s_timeout: got no out_valid want one", nm);
      fails++;
    end else begin
      tests++;
      if (k != 4) begin
        $display("FAIL %s_latency: got %0d want 4", nm, k);
        fails++;
      end
      tests++;
      if (bus.r !== er) begin
        $display("FAIL %s_r: got %h want %h", nm, bus.r, er);
        fails++;
      end
      tests++;
      if (bus.ovf !== eo) begin
        $display("FAIL %s_ovf: got %b want %b", nm, bus.ovf, eo);
        fails++;
      end
    end
  endtask

  task automatic test_wrap();
    run_beat(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0,
             33'h1_0000_0000, 1'b0, "wrap");
  endtask

  task automatic test_sub();
    run_beat(32'd5, 32'd7, 1'b1, 1'b1,
             33'h0_FFFF_FFFE, 1'b0, "sub_neg");
    run_beat(32'd7, 32'd5, 1'b1, 1'b1,
             33'h1_0000_0002, 1'b0, "sub_pos");
  endtask

  task automatic test_ovf();
    run_beat(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0,
             33'h0_8000_0000, 1'b1, "ovf_add");
    run_beat(32'h8000_0000, 32'h1, 1'b0, 1'b1,
             33'h1_7FFF_FFFF, 1'b1, "ovf_sub");
  endtask

  task automatic test_back_to_back();
    int          sent;
    int          got;
    logic        saw_full;
    logic        hold;
    logic [32:0] hold_r;
    logic        hold_o;
    logic [32:0] er;
    sent     = 0;
    got      = 0;
    saw_full = 1'b0;
    hold     = 1'b0;
    hold_r   = '0;
    hold_o   = 1'b0;
    bus.c0   = 1'b0;
    bus.sub  = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      bus.in_valid  = (sent < 10);
      bus.p         = 32'(sent);
      bus.q         = 32'(sent) << 8;
      bus.out_ready = !(c >= 3 && c <= 8);
      @(negedge clk);
      tests++;
      if (bus.in_ready !== (!bus.out_valid | bus.out_ready)) begin
        $display("FAIL b2b_in_ready c%0d: got %b want %b", c,
                 bus.in_ready, !bus.out_valid | bus.out_ready);
        fails++;
      end
      if (hold) begin
        tests++;
        if (bus.out_valid !== 1'b1 || bus.r !== hold_r ||
            bus.ovf !== hold_o) begin
          $display("FAIL b2b_stall c%0d: got %b/%h/%b want 1/%h/%b", c,
                   bus.out_valid, bus.r, bus.ovf, hold_r, hold_o);
          fails++;
        end
      end
      hold   = bus.out_valid & !bus.out_ready;
      hold_r = bus.r;
      hold_o = bus.ovf;
      if (bus.out_valid && !bus.in_ready) saw_full = 1'b1;
      if (bus.in_valid && bus.in_ready) sent++;
      if (bus.out_valid && bus.out_ready) begin
        tests++;
        er = 33'(got * 257);
        if (got >= 10) begin
          $display("FAIL b2b_extra: got result %h want none", bus.r);
          fails++;
        end else if (bus.r !== er || bus.ovf !== 1'b0) begin
          $display("FAIL b2b_r%0d: got %h/%b want %h/0", got,
                   bus.r, bus.ovf, er);
          fails++;
        end
        got++;
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tests++;
    if (got != 10) begin
      $display("FAIL b2b_count: got %0d want 10", got);
      fails++;
    end
    tests++;
    if (!saw_full) begin
      $display("FAIL b2b_backpressure: got in_ready stuck 1 want 0");
      fails++;
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    bus.out_ready = 1'b1;
    bus.c0        = 1'b0;
    bus.sub       = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      bus.in_valid = 1'b1;
      bus.p        = 32'(100 + i);
      bus.q        = 32'd1;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    rst          = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.out_valid !== 1'b0) begin
      $display("FAIL midrst_valid: got %b want 0", bus.out_valid);
      fails++;
    end
    tests++;
    if (bus.in_ready !== 1'b1) begin
      $display("FAIL midrst_ready: got %b want 1", bus.in_ready);
      fails++;
    end
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin
      $display("FAIL midrst_stale: got %0d stale cycles want 0", bad);
      fails++;
    end
    run_beat(32'd3, 32'd4, 1'b0, 1'b0, 33'd7, 1'b0, "post_rst");
  endtask

  task automatic test_sweep();
    logic [64:0] e_r [3][1000];
    logic        e_o [3][1000];
    int          e_t [3][1000];
    int          wr  [3];
    int          rd  [3];
    int          ws  [3];
    int          ns  [3];
    logic [65:0] m;
    int          cyc;
    ws  = '{8, 8, 64};
    ns  = '{1, 8, 4};
    wr  = '{0, 0, 0};
    rd  = '{0, 0, 0};
    cyc = 0;
    while ((rd[0] < 1000 || rd[1] < 1000 || rd[2] < 1000) &&
           cyc < 20000) begin
      @(posedge clk);
      #1;
      cyc++;
      for (int d = 0; d < 3; d++) begin
        sw_iv[d]  = (wr[d] < 1000) && ($urandom_range(0, 3) != 0);
        sw_p[d]   = {$urandom, $urandom};
        sw_q[d]   = {$urandom, $urandom};
        sw_c0[d]  = 1'($urandom_range(0, 1));
        sw_sub[d] = 1'($urandom_range(0, 1));
        sw_or[d]  = (rd[d] < 500) ? 1'b1 : ($urandom_range(0, 2) != 0);
      end
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (sw_iv[d] && sw_ir[d]) begin
          m = ref_add(ws[d], sw_p[d], sw_q[d], sw_c0[d], sw_sub[d]);
          e_r[d][wr[d]] = m[64:0];
          e_o[d][wr[d]] = m[65];
          e_t[d][wr[d]] = cyc + 1;
          wr[d]++;
        end
        if (sw_ov[d] && sw_or[d]) begin
          tests++;
          if (rd[d] >= wr[d]) begin
            $display("FAIL sweep%0d_extra: got %h want none", d, sw_r[d]);
            fails++;
          end else begin
            if (sw_r[d] !== e_r[d][rd[d]] ||
                sw_o[d] !== e_o[d][rd[d]]) begin
              $display("FAIL sweep%0d_beat%0d: got %h/%b want %h/%b", d,
                       rd[d], sw_r[d], sw_o[d], e_r[d][rd[d]],
                       e_o[d][rd[d]]);
              fails++;
            end
            if (rd[d] < 500) begin
              tests++;
              if (cyc + 1 - e_t[d][rd[d]] != ns[d]) begin
                $display("FAIL sweep%0d_latency: got %0d want %0d", d,
                         cyc + 1 - e_t[d][rd[d]], ns[d]);
                fails++;
              end
            end
            rd[d]++;
          end
        end
      end
    end
    for (int d = 0; d < 3; d++) begin
      sw_iv[d] = 1'b0;
      tests++;
      if (rd[d] != 1000) begin
        $display("FAIL sweep%0d_count: got %0d want 1000", d, rd[d]);
        fails++;
      end
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.p         = '0;
    bus.q         = '0;
    bus.c0        = 1'b0;
    bus.sub       = 1'b0;
    for (int d = 0; d < 3; d++) begin
      sw_iv[d]  = 1'b0;
      sw_or[d]  = 1'b1;
      sw_p[d]   = '0;
      sw_q[d]   = '0;
      sw_c0[d]  = 1'b0;
      sw_sub[d] = 1'b0;
    end
    test_reset();
    test_wrap();
    test_sub();
    test_ovf();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
